// File: rtl/router_input_distributor.sv
// Input-port distributor: buffers single-flit packets, XY-routes the head packet
// and presents it on exactly one output lane until that lane's arbiter takes it.
`timescale 1ns/1ps
module router_input_distributor #(
  parameter int PL      = 32,
  parameter int REN     = 5,
  parameter int COORD_W = 2,
  parameter int X_POS   = 0,
  parameter int Y_POS   = 0,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [0:PL-1]            in_data,
  output logic                     in_ready,
  output logic [0:REN*PL-1]        out_data,
  input  logic [REN-1:0]           out_ready,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LANE_LOCAL = 0;
  localparam int LANE_NORTH = 1;
  localparam int LANE_EAST  = 2;
  localparam int LANE_SOUTH = 3;
  localparam int LANE_WEST  = 4;
  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_POS);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_POS);

  logic [0:PL-1]        mem_r [DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic [0:PL-1]        head_s;
  logic [COORD_W-1:0]   dest_x_s;
  logic [COORD_W-1:0]   dest_y_s;
  logic [REN-1:0]       lane_sel_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 not_empty_s;

  assign not_empty_s = (count_r != CW'(0));
  assign in_ready    = (count_r != CW'(DEPTH));
  assign push_s      = in_data[0] && in_ready;
  assign pop_s       = not_empty_s && ((out_ready & lane_sel_s) != REN'(0));
  assign head_s      = mem_r[rd_ptr_r];
  assign dest_x_s    = head_s[1:COORD_W];
  assign dest_y_s    = head_s[COORD_W+1:2*COORD_W];
  assign fill_count  = count_r;

  // Storage is deliberately left out of reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // XY dimension-order route of the head packet (X first), as a one-hot lane select.
  always_comb begin
    lane_sel_s = '0;
    if (dest_x_s > X_C) begin
      lane_sel_s[LANE_EAST] = 1'b1;
    end else if (dest_x_s < X_C) begin
      lane_sel_s[LANE_WEST] = 1'b1;
    end else if (dest_y_s > Y_C) begin
      lane_sel_s[LANE_SOUTH] = 1'b1;
    end else if (dest_y_s < Y_C) begin
      lane_sel_s[LANE_NORTH] = 1'b1;
    end else begin
      lane_sel_s[LANE_LOCAL] = 1'b1;
    end
  end

  // Steer the head packet verbatim onto its lane; every other lane stays zero.
  always_comb begin
    out_data = '0;
    for (int p = 0; p < REN; p++) begin
      if (not_empty_s && lane_sel_s[p]) begin
        out_data[p*PL +: PL] = head_s;
      end else begin
        out_data[p*PL +: PL] = '0;
      end
    end
  end

endmodule

// File: tb/tb_router_input_distributor.sv
// Scoreboard bench for router_input_distributor at router position (1,1):
// stimulus queues expected (lane, packet) pairs, a negedge monitor checks every pop.
`timescale 1ns/1ps
module tb_router_input_distributor;

  localparam int PL    = 32;
  localparam int REN   = 5;
  localparam int DEPTH = 4;

  typedef struct {
    int            lane;
    logic [0:PL-1] data;
  } exp_t;

  logic                   clk;
  logic                   rst_n;
  logic [0:PL-1]          in_data;
  logic                   in_ready;
  logic [0:REN*PL-1]      out_data;
  logic [REN-1:0]         out_ready;
  logic [$clog2(DEPTH):0] fill_count;

  exp_t sb[$];
  int   checks;
  int   passed;

  router_input_distributor #(
    .PL(PL), .REN(REN), .COORD_W(2), .X_POS(1), .Y_POS(1), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_ready(in_ready),
    .out_data(out_data), .out_ready(out_ready), .fill_count(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:PL-1] mk(input logic [1:0] x, input logic [1:0] y,
                                       input logic [26:0] pay);
    logic [0:PL-1] p;
    p       = '0;
    p[0]    = 1'b1;
    p[1:2]  = x;
    p[3:4]  = y;
    p[5:31] = pay;
    return p;
  endfunction

  // Offer a packet until accepted; record the expected lane when the edge takes it.
  task automatic push_pkt(input logic [0:PL-1] p, input int lane);
    exp_t e;
    bit   done;
    done    = 1'b0;
    in_data = p;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.lane = lane;
        e.data = p;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_data = '0;
    if (!done) chk("push_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
    chk("drain_fill_zero", 64'(fill_count), 64'd0);
  endtask

  // Monitor: lanes must be one-hot; a valid lane with its ready set is a transfer.
  always @(negedge clk) begin : monitor
    int            nz;
    int            li;
    logic [0:PL-1] lv;
    exp_t          e;
    if (rst_n) begin
      nz = 0;
      li = 0;
      for (int p = 0; p < REN; p++) begin
        lv = out_data[p*PL +: PL];
        if (lv != '0) begin
          nz++;
          li = p;
        end
      end
      if (nz > 1) chk("lanes_onehot", 64'(nz), 64'd1);
      if (nz == 1 && out_ready[li]) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("pop_lane", 64'(li), 64'(e.lane));
          chk("pop_data", 64'(out_data[li*PL +: PL]), 64'(e.data));
        end
      end
    end
  end

  logic [0:PL-1] route_pk [5];
  int            route_ln [5];

  initial begin
    checks    = 0;
    passed    = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    out_ready = '0;
    route_pk[0] = mk(2'd2, 2'd1, 27'h0000a1); route_ln[0] = 2;
    route_pk[1] = mk(2'd0, 2'd1, 27'h0000b2); route_ln[1] = 4;
    route_pk[2] = mk(2'd1, 2'd2, 27'h0000c3); route_ln[2] = 3;
    route_pk[3] = mk(2'd1, 2'd0, 27'h0000d4); route_ln[3] = 1;
    route_pk[4] = mk(2'd1, 2'd1, 27'h0000e5); route_ln[4] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fill", 64'(fill_count), 64'd0);
    chk("rst_out_zero", 64'(|out_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_zero", 64'(|out_data), 64'd0);

    // Route coverage, consecutive pushes with all lanes ready.
    out_ready = '1;
    for (int i = 0; i < 5; i++) begin
      push_pkt(route_pk[i], route_ln[i]);
      chk("route_fill_one", 64'(fill_count), 64'd1);
    end
    drain();

    // Back-pressure: four accepted, fifth held upstream.
    out_ready = '0;
    for (int i = 0; i < 4; i++) push_pkt(mk(2'd2, 2'd1, 27'(16 + i)), 2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_fill", 64'(fill_count), 64'd4);
    in_data = mk(2'd2, 2'd1, 27'd20);
    repeat (2) @(posedge clk);
    #1;
    chk("full_hold_fill", 64'(fill_count), 64'd4);
    chk("full_head_east", 64'(out_data[2*PL +: PL]), 64'(mk(2'd2, 2'd1, 27'd16)));
    out_ready = 5'b00100;
    push_pkt(mk(2'd2, 2'd1, 27'd20), 2);
    drain();

    // Simultaneous push and pop at count = 1.
    out_ready = '0;
    push_pkt(mk(2'd2, 2'd1, 27'h111), 2);
    out_ready = '1;
    push_pkt(mk(2'd1, 2'd1, 27'h222), 0);
    chk("pushpop_fill", 64'(fill_count), 64'd1);
    chk("pushpop_lane0", 64'(out_data[0*PL +: PL]), 64'(mk(2'd1, 2'd1, 27'h222)));
    drain();

    // Wrap-around stream with half-rate readiness.
    fork
      begin
        for (int i = 0; i < 10; i++) push_pkt(route_pk[i % 5] ^ 32'(i << 8), route_ln[i % 5]);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          out_ready = (i % 2 == 1) ? 5'b11111 : 5'b00000;
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = '1;
    drain();

    // Blocked head: east not ready, local ready, local packet stuck behind.
    out_ready = 5'b00001;
    push_pkt(mk(2'd3, 2'd0, 27'h3e), 2);
    push_pkt(mk(2'd1, 2'd1, 27'h3f), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("blk_fill", 64'(fill_count), 64'd2);
      chk("blk_lane0_zero", 64'(out_data[0*PL +: PL]), 64'd0);
      chk("blk_east_stable", 64'(out_data[2*PL +: PL]), 64'(mk(2'd3, 2'd0, 27'h3e)));
    end
    out_ready = '1;
    drain();

    // Mid-traffic reset drops three buffered packets immediately.
    out_ready = '0;
    for (int i = 0; i < 3; i++) push_pkt(mk(2'd0, 2'd0, 27'(64 + i)), 4);
    chk("pre_rst_fill", 64'(fill_count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_zero", 64'(|out_data), 64'd0);
    chk("midrst_fill", 64'(fill_count), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_zero", 64'(|out_data), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/router_input_distributor.md
Name: router_input_distributor

Overview:
- Input-side counterpart of the router's per-output round-robin arbiter: one instance per router input port.
- Buffers incoming single-flit packets in a small FIFO and computes the XY route for the head packet.
- Steers the head packet onto exactly one of REN output lanes; each lane feeds one output arbiter.
- Pops the head only when the target lane signals ready.

Parameters:
- PL, 32, packet width in bits; MSB-first indexing [0:PL-1].
- REN, 5, number of router ports; lane order 0=local, 1=north, 2=east, 3=south, 4=west.
- COORD_W, 2, width of each destination coordinate field.
- X_POS, 0, this router's X coordinate.
- Y_POS, 0, this router's Y coordinate.
- DEPTH, 4, FIFO depth in packets; must be a power of 2, ≥2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- in_data  input  PL  incoming packet; bit 0 = valid, bits [1:COORD_W] = dest X, bits [COORD_W+1:2*COORD_W] = dest Y, remainder = payload.
- in_ready  output  1  FIFO can accept a packet this cycle.
- out_data  output  REN*PL  lane p occupies bits [p*PL +: PL]; lane bit 0 = valid.
- out_ready  input  REN  lane p's arbiter consumes the presented packet this cycle.
- fill_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset: rd/wr pointers = 0, count = 0, FIFO storage not cleared.
- Reset outputs: out_data = all zero, in_ready = 1, fill_count = 0.
- Mid-operation reset drops all buffered packets immediately.
- Push: on a clk edge where in_data[0]=1 and in_ready=1, write in_data at wr_ptr; wr_ptr wraps modulo DEPTH.
- in_ready = (count != DEPTH). Combinational from count; no dependence on same-cycle pop (no full-bypass).
- Push attempted while full (in_ready=0): ignored; upstream holds the packet.
- Packets with in_data[0]=0 are never written.
- Route of head packet (combinational), unsigned compares:
  - dest X > X_POS -> east (2)
  - dest X < X_POS -> west (4)
  - else dest Y > Y_POS -> south (3)
  - else dest Y < Y_POS -> north (1)
  - else local (0)
- Output, count != 0: lane[route] = head packet verbatim (valid bit = 1); all other lanes = all zero.
- Output, empty: all lanes zero.
- Pop: on a clk edge with count != 0 and out_ready[route]=1, rd_ptr advances (wraps modulo DEPTH).
- out_ready on non-target lanes is ignored.
- Head-of-line blocking is intentional: the head waits on its lane while later packets wait behind it.
- Latency: a packet pushed at edge t appears on its lane right after edge t when the FIFO was empty (1 cycle). Otherwise it appears after all older packets pop.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Legal when full: in_ready=0, so only the pop occurs.
  - Legal when count=1: the new packet becomes head after the edge.
- Out-of-mesh destinations are not checked; the routing rule is applied as-is.
- fill_count = count, updated on the clock edge.

Test Plan:
- Reset, then check idle state -> in_ready=1, fill_count=0, all lanes 0. Hold rst_n low mid-traffic with 3 buffered -> outputs return to 0 immediately.
- Route coverage (X_POS=1, Y_POS=1, out_ready all 1), push dest (2,1),(0,1),(1,2),(1,0),(1,1) on consecutive cycles -> each appears on lanes 2,4,3,1,0 respectively, one per cycle, 1-cycle latency.
- Back-pressure: out_ready=0, push 5 packets with DEPTH=4 -> first 4 accepted, in_ready=0 after the 4th, 5th held upstream, fill_count=4. Raise out_ready[target] -> one pop per cycle in order.
- Simultaneous push/pop at count=1 -> fill_count stays 1; new packet on its lane next cycle.
- Wrap-around: stream 10 packets with out_ready toggling every other cycle -> order preserved across pointer wrap, no loss or duplication.
- Blocked head: head routed east with out_ready[2]=0, out_ready[0]=1, second packet local -> nothing pops, lane 0 stays 0, east lane holds the head packet stable.
